// File: rtl/mips_regfile.sv
// mips_regfile: 2**ADDR_W x DATA_W register file, two async reads, one write.
// r0 reads zero; define MIPS_REGFILE_BYPASS_EN to forward WriteData to reads.
module mips_regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic [ADDR_W-1:0] ReadReg1,
   input  logic [ADDR_W-1:0] ReadReg2,
   input  logic [ADDR_W-1:0] WriteReg,
   input  logic [DATA_W-1:0] WriteData,
   input  logic              RegWrite,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2
);

   localparam int NREG = 1 << ADDR_W;

   logic [DATA_W-1:0] regs_q [1:NREG-1];
   logic [DATA_W-1:0] regs_d [1:NREG-1];
   logic              wr_en;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;

   assign wr_en = RegWrite && (WriteReg != '0);

   // next state: only the addressed register takes WriteData
   always_comb begin
      regs_d = regs_q;
      for (int i = 1; i < NREG; i++) begin
         if (wr_en && (WriteReg == ADDR_W'(i))) begin
            regs_d[i] = WriteData;
         end
      end
   end

   // storage: async clear, otherwise load next state every edge
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 1; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // read port 1: index 0 has no storage and falls through to zero
   always_comb begin
      rd1 = '0;
      for (int i = 1; i < NREG; i++) begin
         if (ReadReg1 == ADDR_W'(i)) begin
            rd1 = regs_q[i];
         end
      end
`ifdef MIPS_REGFILE_BYPASS_EN
      if (Reset_n && wr_en && (ReadReg1 == WriteReg)) begin
         rd1 = WriteData;
      end
`endif
   end

   // read port 2: same structure as port 1, fully independent
   always_comb begin
      rd2 = '0;
      for (int i = 1; i < NREG; i++) begin
         if (ReadReg2 == ADDR_W'(i)) begin
            rd2 = regs_q[i];
         end
      end
`ifdef MIPS_REGFILE_BYPASS_EN
      if (Reset_n && wr_en && (ReadReg2 == WriteReg)) begin
         rd2 = WriteData;
      end
`endif
   end

   assign ReadData1 = rd1;
   assign ReadData2 = rd2;

endmodule
